// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types. pipe_stage takes its default payload width from
// the fetch/decode latch payload defined here.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  // Fetch -> decode latch payload
  typedef struct packed {
    word_t imemaddr;
    word_t imemload;
  } if_id_t;

endpackage

// File: rtl/pipe_skid_entry.sv
// One pipeline holding slot: valid bit plus data register.
// Priority within an enabled cycle is clear > load > drop.
// A drop clears only the valid bit, so q keeps the last loaded value.
module pipe_skid_entry #(
  parameter int                DATA_W  = 64,
  parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              en,
  input  logic              clr,
  input  logic              ld,
  input  logic              drop,
  input  logic [DATA_W-1:0] d,
  output logic              valid,
  output logic [DATA_W-1:0] q
);

  // slot register: async clear, frozen while en is low
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid <= 1'b0;
      q     <= CLR_VAL;
    end else if (en) begin
      if (clr) begin
        valid <= 1'b0;
        q     <= CLR_VAL;
      end else if (ld) begin
        valid <= 1'b1;
        q     <= d;
      end else if (drop) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pipe_stage.sv
// Generic valid/ready pipeline latch (if_id, id_ex, ex_mem, mem_wb), sized by
// DATA_W alone.
// Default build: a single entry, with in_ready taken combinationally from
// out_ready.
// PIPE_STAGE_SKID_EN: adds a skid entry, so in_ready is a register output
// (~skid_valid) and the stage holds up to two entries at full throughput.
module pipe_stage
  import cpu_types_pkg::*;
#(
  parameter int                DATA_W  = $bits(if_id_t),
  parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              en,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        count
);

  logic              in_fire, out_fire;
  logic              main_ld, main_drop, main_valid;
  logic [DATA_W-1:0] main_d, main_q;

  assign in_fire   = en & in_valid & in_ready;
  assign out_fire  = en & out_valid & out_ready;
  assign out_valid = main_valid;
  assign out_data  = main_q;

  // Head entry, which is what downstream sees. A flush has priority over any
  // load, so an in_fire in the same cycle as a flush is dropped.
  pipe_skid_entry #(.DATA_W(DATA_W), .CLR_VAL(CLR_VAL)) u_main (
    .CLK   (CLK),
    .nRST  (nRST),
    .en    (en),
    .clr   (flush),
    .ld    (main_ld),
    .drop  (main_drop),
    .d     (main_d),
    .valid (main_valid),
    .q     (main_q)
  );

`ifdef PIPE_STAGE_SKID_EN
  logic              skid_ld, skid_drop, skid_valid;
  logic [DATA_W-1:0] skid_q;

  // Overflow entry, filled only when the head is occupied and not leaving.
  pipe_skid_entry #(.DATA_W(DATA_W), .CLR_VAL(CLR_VAL)) u_skid (
    .CLK   (CLK),
    .nRST  (nRST),
    .en    (en),
    .clr   (flush),
    .ld    (skid_ld),
    .drop  (skid_drop),
    .d     (in_data),
    .valid (skid_valid),
    .q     (skid_q)
  );

  assign in_ready = ~skid_valid;

  // Steering: on a pop with skid valid, skid moves to head and any new entry
  // goes to skid. Otherwise a new entry goes to head if head is free or leaving.
  always_comb begin
    main_ld   = (out_fire & skid_valid) |
                (in_fire & ~skid_valid & (~main_valid | out_fire));
    main_d    = skid_valid ? skid_q : in_data;
    main_drop = out_fire;
    skid_ld   = in_fire & main_valid & (~out_fire | skid_valid);
    skid_drop = out_fire & skid_valid;
    count     = {1'b0, main_valid} + {1'b0, skid_valid};
  end
`else
  assign in_ready = ~main_valid | out_ready;

  // Single entry: a push reloads head, a pop without a push empties it.
  always_comb begin
    main_ld   = in_fire;
    main_d    = in_data;
    main_drop = out_fire;
    count     = {1'b0, main_valid};
  end
`endif

endmodule

// File: tb/tb_pipe_stage.sv
// Directed bench for pipe_stage; the backpressure and reset-while-full vectors
// follow whichever PIPE_STAGE_SKID_EN build is compiled.
module tb_pipe_stage;

  localparam int DATA_W = 64;

  logic              CLK = 1'b0;
  logic              nRST, en, flush, in_valid, in_ready, out_valid, out_ready;
  logic [DATA_W-1:0] in_data, out_data;
  logic [1:0]        count;

  int checks = 0;
  int failures = 0;

  pipe_stage #(.DATA_W(DATA_W), .CLR_VAL('0)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .en        (en),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // advance one clock, land 1ns after the rising edge
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    nRST = 1'b0; en = 1'b0; flush = 1'b0; in_valid = 1'b0;
    in_data = '0; out_ready = 1'b0;
    #3;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_count",     64'(count),     64'd0);
    chk("rst_out_data",  out_data,       64'd0);
    step();
    nRST = 1'b1;
    step();

    // first transaction: visible one cycle after in_fire
    en = 1'b1; in_valid = 1'b1; in_data = 64'hDEADBEEF_00000004; out_ready = 1'b1;
    #1 chk("first_in_ready", 64'(in_ready), 64'd1);
    step();
    chk("first_out_valid", 64'(out_valid), 64'd1);
    chk("first_out_data",  out_data,       64'hDEADBEEF_00000004);
    chk("first_count",     64'(count),     64'd1);

    // streaming at full rate
    in_data = 64'h1;
    step();
    chk("stream1_data", out_data, 64'h1);
    in_data = 64'h2;
    #1 chk("stream2_in_ready", 64'(in_ready), 64'd1);
    step();
    chk("stream2_data", out_data, 64'h2);
    in_data = 64'h3;
    step();
    chk("stream3_data", out_data, 64'h3);
    chk("stream3_valid", 64'(out_valid), 64'd1);
    in_valid = 1'b0;
    step();
    chk("drain_valid", 64'(out_valid), 64'd0);
    chk("drain_count", 64'(count),     64'd0);
    chk("drain_data_kept", out_data,   64'h3);

    // en=0 freezes everything, flush included
    in_valid = 1'b1; in_data = 64'h5; out_ready = 1'b0;
    step();
    chk("hold5_data", out_data, 64'h5);
    en = 1'b0; flush = 1'b1; in_data = 64'h9;
    step();
    chk("en0_data",  out_data,        64'h5);
    chk("en0_count", 64'(count),      64'd1);
    chk("en0_valid", 64'(out_valid),  64'd1);
    en = 1'b1;
    step();
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_data",  out_data,       64'd0);
    chk("flush_count", 64'(count),     64'd0);
    flush = 1'b0; in_valid = 1'b0;
    step();
    chk("post_flush_valid", 64'(out_valid), 64'd0);

`ifdef PIPE_STAGE_SKID_EN
    // skid fills under backpressure, then drains in order
    out_ready = 1'b0; in_valid = 1'b1; in_data = 64'hA;
    step();
    in_data = 64'hB;
    step();
    chk("skid_count2",   64'(count),    64'd2);
    chk("skid_in_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b0; out_ready = 1'b1;
    #1 chk("skid_head_a", out_data, 64'hA);
    chk("skid_in_ready_comb", 64'(in_ready), 64'd0);
    step();
    chk("skid_head_b",     out_data,       64'hB);
    chk("skid_count1",     64'(count),     64'd1);
    chk("skid_in_ready_1", 64'(in_ready),  64'd1);
    step();
    chk("skid_empty", 64'(out_valid), 64'd0);

    // reset while holding two entries
    out_ready = 1'b0; in_valid = 1'b1; in_data = 64'hC;
    step();
    in_data = 64'hD;
    step();
    chk("pre_rst_count", 64'(count), 64'd2);
`else
    // combinational in_ready from out_ready
    out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h6;
    step();
    in_data = 64'h77;
    #1 chk("bp_in_ready0", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    #1 chk("bp_in_ready1", 64'(in_ready), 64'd1);
    out_ready = 1'b0;
    step();
    chk("bp_hold_data",  out_data,   64'h6);
    chk("bp_hold_count", 64'(count), 64'd1);
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk("bp_pop_valid", 64'(out_valid), 64'd0);

    // reset while holding an entry
    out_ready = 1'b0; in_valid = 1'b1; in_data = 64'hC;
    step();
    chk("pre_rst_count", 64'(count), 64'd1);
`endif
    in_valid = 1'b0;
    nRST = 1'b0;
    #1;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_count", 64'(count),     64'd0);
    chk("midrst_data",  out_data,       64'd0);
    nRST = 1'b1;
    in_valid = 1'b1; in_data = 64'h7; out_ready = 1'b1;
    step();
    chk("post_rst_data",  out_data,        64'h7);
    chk("post_rst_valid", 64'(out_valid),  64'd1);
    chk("post_rst_count", 64'(count),      64'd1);
    in_valid = 1'b0;
    step();
    chk("post_rst_drain", 64'(out_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_stage.md
PIPE_STAGE -- requirements
Module: pipe_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 64, payload width (e.g. {imemaddr, imemload}).
REQ-002 SHALL have parameter CLR_VAL, default '0, value loaded into data registers on reset/flush.
REQ-003 SHALL have port CLK  input  1  clock, rising-edge.
REQ-004 SHALL have port nRST  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port en  input  1  global pipeline advance (hit/pipeline_control); no state change when 0.
REQ-006 SHALL have port flush  input  1  discard all held entries.
REQ-007 SHALL have port in_valid  input  1  upstream entry present.
REQ-008 SHALL have port in_ready  output  1  stage can accept.
REQ-009 SHALL have port in_data  input  DATA_W  upstream payload.
REQ-010 SHALL have port out_valid  output  1  head entry present.
REQ-011 SHALL have port out_ready  input  1  downstream accepts.
REQ-012 SHALL have port out_data  output  DATA_W  head payload.
REQ-013 SHALL have port count  output  2  entries held (0..2).

Function
REQ-014 SHALL define in_fire = en & in_valid & in_ready, out_fire = en & out_valid & out_ready; transfers occur only on fires.
REQ-015 SHALL hold all state, outputs unchanged, when en=0, regardless of flush, in_valid, out_ready.
REQ-016 SHALL, on en & flush, set all valids 0, data regs CLR_VAL, count 0 next cycle; any same-cycle in_fire is dropped.
REQ-017 SHALL present an accepted entry on out_valid/out_data exactly 1 cycle after in_fire when stage was empty or emptying.
REQ-018 SHALL deliver entries in acceptance order; no loss, no duplication.
REQ-019 SHALL hold out_data stable while out_valid=1 and no out_fire.
REQ-020 SHALL keep out_data at last loaded value (or CLR_VAL) when out_valid=0.
REQ-021 SHALL keep count = number of valid entries, updating the cycle after each fire/flush.

Reset
REQ-022 SHALL, on nRST=0, immediately clear all valids, data regs to CLR_VAL, count 0, out_valid 0.
REQ-023 SHALL drop any in-flight entries on reset mid-stream; first post-reset in_fire is delivered first.

Configuration
REQ-024 SHALL use macro PIPE_STAGE_SKID_EN.
REQ-025 SHALL, without PIPE_STAGE_SKID_EN, hold one entry (count<=1), in_ready = ~out_valid | out_ready (combinational path from out_ready).
REQ-026 SHALL, with PIPE_STAGE_SKID_EN, hold main+skid entries (count<=2), in_ready = ~skid_valid (registered, no combinational path from out_ready).
REQ-027 SHALL, with skid, route in_fire to skid when main valid and no out_fire; on out_fire with skid valid move skid to main, simultaneous in_fire goes to skid.
REQ-028 SHALL, with skid, support full throughput: in_fire and out_fire every cycle at count=1.

Structure
REQ-029 SHALL take word_t and payload typedefs from cpu_types_pkg; no new package constants.
REQ-030 SHALL be a single module; skid entry may be a sub-module pipe_skid_entry (valid+data register).
REQ-031 SHALL be instantiable for if_id, id_ex, ex_mem, mem_wb by DATA_W alone.

Verification
REQ-032 Reset then en=1, in_valid=1, in_data=0xDEADBEEF_00000004, out_ready=1 -> next cycle out_valid=1, out_data=0xDEADBEEF_00000004, count=1.
REQ-033 Stream 0x1,0x2,0x3 with en=1, out_ready=1 each cycle -> out_data 0x1,0x2,0x3 on consecutive cycles, in_ready stays 1.
REQ-034 Stage holds 0x5, en=0, flush=1, in_valid=1 -> out_data stays 0x5, count stays 1; en=1 next cycle -> out_valid=0, out_data=CLR_VAL, 0x new input dropped.
REQ-035 SKID_EN: out_ready=0, push 0xA,0xB -> count=2, in_ready=0; out_ready=1 -> 0xA then 0xB, in_ready=1 cycle after first pop.
REQ-036 No SKID_EN: out_valid=1, out_ready=0 -> in_ready=0; out_ready=1 same cycle -> in_ready=1.
REQ-037 Assert nRST low while count=2 -> out_valid=0, count=0 immediately; push 0x7 after release -> out_data 0x7.
